router_pkt_tx: RTL

Packet transmitter that drives the router's input port: `data`, `packet_valid`, honouring `suspend_data_in` and sampling `err`. It accepts a packet request plus payload bytes from a test or upstream source, buffers the whole payload, then serialises header, payload and parity onto the router input. It reports per-packet completion and any parity error the router flags. It is the source-side counterpart of `router` and sits between stimulus/upstream logic and the router's input pins.

---
 rtl/router_pkt_tx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the router input port: buffers a payload, then sends header, payload and
// parity, and reports the router's err flag per packet. Optional build macro: ROUTER_TX_ERR_INJECT_EN.
module router_pkt_tx #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned ERR_WINDOW = 2
) (
  input  logic       clock,
  input  logic       reset,
`ifdef ROUTER_TX_ERR_INJECT_EN
  input  logic       inject_err,
`endif
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_addr,
  input  logic [5:0] req_len,
  input  logic [7:0] pay_data,
  input  logic       pay_valid,
  output logic       pay_ready,
  output logic [7:0] data,
  output logic       packet_valid,
  input  logic       suspend_data_in,
  input  logic       err,
  output logic       done,
  output logic       done_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StHdr,
    StPayload,
    StParity,
    StCheck,
    StGap
  } state_e;

  state_e      state_q;
  logic [1:0]  addr_q;
  logic [5:0]  len_q;
  logic [5:0]  cnt_q;
  logic [7:0]  par_q;
  logic [7:0]  par_out;
  logic [2:0]  win_q;
  logic [3:0]  gap_q;
  logic        flag_q;
  logic [7:0]  data_q;
  logic        pv_q;
  logic        done_q;
  logic        done_err_q;
  logic [7:0]  mem_q [64];

`ifdef ROUTER_TX_ERR_INJECT_EN
  logic inj_q;
  assign par_out = inj_q ? ~par_q : par_q;
`else
  assign par_out = par_q;
`endif

  // Readies are gated by reset so nothing is accepted while reset is held.
  assign req_ready    = (state_q == StIdle) && !reset;
  assign pay_ready    = (state_q == StLoad) && !reset;
  assign busy         = (state_q != StIdle);
  assign data         = data_q;
  assign packet_valid = pv_q;
  assign done         = done_q;
  assign done_err     = done_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      par_q      <= '0;
      win_q      <= '0;
      gap_q      <= '0;
      flag_q     <= 1'b0;
      data_q     <= '0;
      pv_q       <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
`ifdef ROUTER_TX_ERR_INJECT_EN
      inj_q      <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q <= req_addr;
            len_q  <= req_len;
            cnt_q  <= '0;
            // Header is folded into the accumulator up front.
            par_q  <= {req_len, req_addr};
`ifdef ROUTER_TX_ERR_INJECT_EN
            inj_q  <= inject_err;
`endif
            if (req_len == 6'd0) begin
              state_q <= StHdr;
              data_q  <= {req_len, req_addr};
              pv_q    <= 1'b1;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (pay_valid) begin
            mem_q[cnt_q] <= pay_data;
            par_q        <= par_q ^ pay_data;
            if (cnt_q == len_q - 6'd1) begin
              state_q <= StHdr;
              cnt_q   <= '0;
              data_q  <= {len_q, addr_q};
              pv_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        StHdr: begin
          if (!suspend_data_in) begin
            if (len_q == 6'd0) begin
              state_q <= StParity;
              data_q  <= par_out;
              pv_q    <= 1'b0;
            end else begin
              state_q <= StPayload;
              data_q  <= mem_q[0];
            end
          end
        end
        StPayload: begin
          if (!suspend_data_in) begin
            if (cnt_q == len_q - 6'd1) begin
              state_q <= StParity;
              data_q  <= par_out;
              pv_q    <= 1'b0;
            end else begin
              cnt_q  <= cnt_q + 6'd1;
              data_q <= mem_q[cnt_q + 6'd1];
            end
          end
        end
        StParity: begin
          state_q <= StCheck;
          data_q  <= '0;
          win_q   <= '0;
          flag_q  <= 1'b0;
        end
        StCheck: begin
          flag_q <= flag_q | err;
          // The last window cycle's err still counts toward done_err.
          if (win_q == 3'(ERR_WINDOW - 1)) begin
            done_q     <= 1'b1;
            done_err_q <= flag_q | err;
            gap_q      <= '0;
            state_q    <= (GAP_CYCLES == 0) ? StIdle : StGap;
          end else begin
            win_q <= win_q + 3'd1;
          end
        end
        StGap: begin
          if (gap_q == 4'(GAP_CYCLES - 1)) begin
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
